// File: rtl/bubl_snd_pkg.sv
// rtl/bubl_snd_pkg.sv - shared constants and helpers for the sound mixer
package bubl_snd_pkg;

    localparam logic [7:0] UNITY_GAIN = 8'h10;

    localparam int DEF_W0     = 16;
    localparam int DEF_W1     = 16;
    localparam int DEF_W2     = 10;
    localparam int DEF_W3     = 8;
    localparam int DEF_WOUT   = 16;
    localparam int DEF_AVG_SH = 10;

    // Width of the value handed to the saturation helpers; wide enough for any mixer sum
    localparam int SAT_IN_W = 32;
    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = SAT_IN_W'((1 <<< (DEF_WOUT-1)) - 1);
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -SAT_MAX - SAT_IN_W'(1);

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic is_sat(input logic signed [SAT_IN_W-1:0] x);
        return (x > SAT_MAX) || (x < SAT_MIN);
    endfunction

    function automatic logic signed [DEF_WOUT-1:0] saturate(input logic signed [SAT_IN_W-1:0] x);
        if (x > SAT_MAX)      return DEF_WOUT'(SAT_MAX);
        else if (x < SAT_MIN) return DEF_WOUT'(SAT_MIN);
        else                  return DEF_WOUT'(x);
    endfunction

endpackage

// File: rtl/bubl_snd_mix_if.sv
// rtl/bubl_snd_mix_if.sv - channel inputs, gains and mixed outputs of bubl_snd_mix (BUBL_MIX_PEAK_EN adds peak)
interface bubl_snd_mix_if
    import bubl_snd_pkg::*;
#(
    parameter int W0   = DEF_W0,
    parameter int W1   = DEF_W1,
    parameter int W2   = DEF_W2,
    parameter int W3   = DEF_W3,
    parameter int WOUT = DEF_WOUT
);
    logic                   cen;
    logic signed [W0-1:0]   fm0_snd;
    logic signed [W1-1:0]   fm1_snd;
    logic        [W2-1:0]   psg_snd;
    logic signed [W3-1:0]   ch3;
    logic        [7:0]      gain0;
    logic        [7:0]      gain1;
    logic        [7:0]      gain2;
    logic        [7:0]      gain3;
    logic signed [W2-1:0]   psg_dc;
    logic signed [WOUT-1:0] snd;
`ifdef BUBL_MIX_PEAK_EN
    logic                   peak;

    modport master (output cen, fm0_snd, fm1_snd, psg_snd, ch3, gain0, gain1, gain2, gain3,
                    input  psg_dc, snd, peak);
    modport slave  (input  cen, fm0_snd, fm1_snd, psg_snd, ch3, gain0, gain1, gain2, gain3,
                    output psg_dc, snd, peak);
`else
    modport master (output cen, fm0_snd, fm1_snd, psg_snd, ch3, gain0, gain1, gain2, gain3,
                    input  psg_dc, snd);
    modport slave  (input  cen, fm0_snd, fm1_snd, psg_snd, ch3, gain0, gain1, gain2, gain3,
                    output psg_dc, snd);
`endif
endinterface

// File: rtl/bubl_psg_dcrm.sv
// rtl/bubl_psg_dcrm.sv - running-average DC remover for the unsigned PSG sum
module bubl_psg_dcrm #(
    parameter int W2     = 10,
    parameter int AVG_SH = 10
) (
    input  logic                 clk,
    input  logic                 snd_rstn,
    input  logic                 cen,
    input  logic        [W2-1:0] din,
    output logic signed [W2-1:0] dout
);
    localparam int AW = W2 + AVG_SH;

    logic        [AW-1:0] acc_q, acc_d;
    logic        [W2-1:0] avg;
    logic signed [W2:0]   diff;
    logic signed [W2-1:0] dout_d;

    // Leaky average: acc holds 2^AVG_SH times the mean, so it can never exceed AW bits
    always_comb begin
        avg    = acc_q[AW-1:AVG_SH];
        acc_d  = acc_q + AW'(din) - AW'(avg);
        diff   = $signed({1'b0, din}) - $signed({1'b0, avg});
        dout_d = W2'(diff >>> 1);
    end

    // Accumulator and halved offset-free output advance on the sound clock enable
    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) begin
            acc_q <= '0;
            dout  <= '0;
        end else if (cen) begin
            acc_q <= acc_d;
            dout  <= dout_d;
        end
    end

endmodule

// File: rtl/bubl_snd_mix.sv
// rtl/bubl_snd_mix.sv - PSG DC removal plus four-channel gain mixer with saturation; option BUBL_MIX_PEAK_EN
module bubl_snd_mix
    import bubl_snd_pkg::*;
#(
    parameter int W0     = DEF_W0,
    parameter int W1     = DEF_W1,
    parameter int W2     = DEF_W2,
    parameter int W3     = DEF_W3,
    parameter int WOUT   = DEF_WOUT,
    parameter int AVG_SH = DEF_AVG_SH
) (
    input  logic           clk,
    input  logic           snd_rstn,
    bubl_snd_mix_if.slave  bus
);
    // Two guard bits above the widest channel, then 8 gain bits for the product
    localparam int WM = max4(W0, W1, W2, W3) + 2;
    localparam int PW = WM + 8;
    localparam int SW = PW + 2;

    logic signed [W2-1:0]       psg_dc_w;
    logic signed [PW-1:0]       p0_d, p1_d, p2_d, p3_d;
    logic signed [PW-1:0]       p0_q, p1_q, p2_q, p3_q;
    logic signed [SW-1:0]       sum_w;
    logic signed [SAT_IN_W-1:0] sat_in;
    logic signed [WOUT-1:0]     snd_d, snd_q;

    bubl_psg_dcrm #(
        .W2     (W2),
        .AVG_SH (AVG_SH)
    ) u_dcrm (
        .clk      (clk),
        .snd_rstn (snd_rstn),
        .cen      (bus.cen),
        .din      (bus.psg_snd),
        .dout     (psg_dc_w)
    );

    // Stage 1: value-preserving sign extension times unsigned 4.4 gain
    always_comb begin
        p0_d = PW'(bus.fm0_snd) * $signed(PW'({1'b0, bus.gain0}));
        p1_d = PW'(bus.fm1_snd) * $signed(PW'({1'b0, bus.gain1}));
        p2_d = PW'(psg_dc_w)    * $signed(PW'({1'b0, bus.gain2}));
        p3_d = PW'(bus.ch3)     * $signed(PW'({1'b0, bus.gain3}));
    end

    // Stage 2: drop the gain fraction bits and clamp into the output range
    always_comb begin
        sum_w  = SW'(p0_q) + SW'(p1_q) + SW'(p2_q) + SW'(p3_q);
        sat_in = SAT_IN_W'(sum_w >>> 4);
        snd_d  = WOUT'(saturate(sat_in));
    end

    // Product and output pipeline registers, frozen while cen is low
    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn) begin
            p0_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            p3_q  <= '0;
            snd_q <= '0;
        end else if (bus.cen) begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            p2_q  <= p2_d;
            p3_q  <= p3_d;
            snd_q <= snd_d;
        end
    end

`ifdef BUBL_MIX_PEAK_EN
    logic peak_q;

    // Sticky flag: any clipped output sample since reset
    always_ff @(posedge clk or negedge snd_rstn) begin
        if (!snd_rstn)    peak_q <= 1'b0;
        else if (bus.cen) peak_q <= peak_q | is_sat(sat_in);
    end

    assign bus.peak = peak_q;
`endif

    assign bus.psg_dc = psg_dc_w;
    assign bus.snd    = snd_q;

endmodule

// File: tb/tb_bubl_snd_mix.sv
// tb/tb_bubl_snd_mix.sv - randomized scoreboard bench for bubl_snd_mix
module tb_bubl_snd_mix;
    import bubl_snd_pkg::*;

    logic clk = 1'b0;
    logic snd_rstn;
    always #5 clk = ~clk;

    bubl_snd_mix_if bus ();

    bubl_snd_mix dut (
        .clk      (clk),
        .snd_rstn (snd_rstn),
        .bus      (bus)
    );

    typedef struct {
        int snd;
        int pdc;
        bit peak;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int s_fm0, s_fm1, s_psg, s_ch3;
    int s_g[4];

    longint m_acc;
    int     m_pdc;
    longint m_stage;
    int     m_snd;
    bit     m_peak;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_pdc = 0; m_stage = 0; m_snd = 0; m_peak = 0;
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: PSG mean tracked over 1024 ticks, output = clamp(sum(x*g)/16, floored)
    task automatic model_step();
        int     avg, diff, new_pdc, new_snd;
        longint new_stage, q;
        bit     sat;
        avg       = int'(m_acc / 1024);
        diff      = s_psg - avg;
        new_pdc   = diff >>> 1;
        new_stage = longint'(s_fm0) * s_g[0] + longint'(s_fm1) * s_g[1]
                  + longint'(m_pdc) * s_g[2] + longint'(s_ch3) * s_g[3];
        q         = m_stage >>> 4;
        sat       = (q > 32767) || (q < -32768);
        new_snd   = (q > 32767) ? 32767 : (q < -32768) ? -32768 : int'(q);
        m_acc     = m_acc + s_psg - avg;
        m_pdc     = new_pdc;
        m_stage   = new_stage;
        m_snd     = new_snd;
        m_peak    = m_peak | sat;
    endtask

    task automatic drive();
        bus.fm0_snd = 16'(s_fm0);
        bus.fm1_snd = 16'(s_fm1);
        bus.psg_snd = 10'(s_psg);
        bus.ch3     = 8'(s_ch3);
        bus.gain0   = 8'(s_g[0]);
        bus.gain1   = 8'(s_g[1]);
        bus.gain2   = 8'(s_g[2]);
        bus.gain3   = 8'(s_g[3]);
    endtask

    task automatic tick(input bit c);
        exp_t e;
        @(negedge clk);
        drive();
        bus.cen = c;
        if (c) begin
            model_step();
            e.snd = m_snd; e.pdc = m_pdc; e.peak = m_peak;
            sb_q.push_back(e);
        end
    endtask

    task automatic zero_inputs();
        s_fm0 = 0; s_fm1 = 0; s_psg = 0; s_ch3 = 0;
        for (int i = 0; i < 4; i++) s_g[i] = 0;
    endtask

    // Monitor: every enabled edge retires one expected sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (bus.cen && snd_rstn) begin
                #1;
                if (sb_q.size() == 0) begin
                    check("scoreboard_empty", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("snd", longint'(bus.snd), e.snd);
                    check("psg_dc", longint'(bus.psg_dc), e.pdc);
`ifdef BUBL_MIX_PEAK_EN
                    check("peak", longint'(bus.peak), longint'(e.peak));
`endif
                end
            end
        end
    end

    initial begin
        int gl[3];
        snd_rstn = 1'b0;
        bus.cen  = 1'b0;
        zero_inputs();
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_snd", longint'(bus.snd), 0);
        check("reset_psg_dc", longint'(bus.psg_dc), 0);
        snd_rstn = 1'b1;

        // Unity gain on FM0, two-tick latency, frozen while cen is low
        s_fm0 = 1000; s_g[0] = 16;
        tick(1); tick(1);
        repeat (5) tick(0);
        @(posedge clk); #1;
        check("hold_cen_low", longint'(bus.snd), 1000);

        gl[0] = 8; gl[1] = 32; gl[2] = 0;
        for (int i = 0; i < 3; i++) begin
            s_g[0] = gl[i];
            tick(1); tick(1);
        end
        @(posedge clk); #1;
        check("gain_mute", longint'(bus.snd), 0);

        // Full-scale positive and negative saturation
        s_fm0 = 30000; s_fm1 = 30000; s_g[0] = 16; s_g[1] = 16;
        repeat (3) tick(1);
        @(posedge clk); #1;
        check("sat_pos", longint'(bus.snd), 32767);
        s_fm0 = -30000; s_fm1 = -30000;
        repeat (3) tick(1);
        @(posedge clk); #1;
        check("sat_neg", longint'(bus.snd), -32768);
`ifdef BUBL_MIX_PEAK_EN
        check("peak_sticky", longint'(bus.peak), 1);
`endif

        // Asynchronous reset in the middle of nonzero traffic
        s_fm0 = 1234; s_psg = 300;
        for (int i = 0; i < 4; i++) s_g[i] = 16;
        repeat (3) tick(1);
        @(negedge clk);
        bus.cen = 1'b0;
        #2 snd_rstn = 1'b0;
        #1;
        check("async_rst_snd", longint'(bus.snd), 0);
        check("async_rst_psg_dc", longint'(bus.psg_dc), 0);
        zero_inputs();
        model_reset();
        sb_q.delete();
        @(negedge clk);
        snd_rstn = 1'b1;
        repeat (5) tick(1);

        // PSG step response of the DC remover
        s_psg = 512;
        tick(1);
        @(posedge clk); #1;
        check("psg_first_tick", longint'(bus.psg_dc), 256);
        repeat (20 * 1024) tick(1);
        @(posedge clk); #1;
        check("psg_settled", longint'(iabs(int'(bus.psg_dc)) <= 1), 1);

        s_fm0 = 100; s_fm1 = -50; s_ch3 = -4;
        for (int i = 0; i < 4; i++) s_g[i] = 16;
        repeat (3) tick(1);
        @(posedge clk); #1;
        check("mix_46", longint'(iabs(int'(bus.snd) - 46) <= 1), 1);

        s_psg = 0;
        tick(1);
        @(posedge clk); #1;
        check("psg_step_down", longint'(iabs(int'(bus.psg_dc) + 256) <= 1), 1);

        // Randomized traffic with irregular clock enable
        repeat (3000) begin
            s_fm0 = int'($signed(16'($urandom)));
            s_fm1 = int'($signed(16'($urandom)));
            s_psg = int'($urandom_range(1023));
            s_ch3 = int'($signed(8'($urandom)));
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(5))
                    0:       s_g[i] = 0;
                    1:       s_g[i] = 255;
                    2:       s_g[i] = 16;
                    default: s_g[i] = int'($urandom_range(255));
                endcase
            end
            tick($urandom_range(3) != 0);
        end
        repeat (3) tick(0);
        check("scoreboard_drained", longint'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bubl_snd_mix.md
Name: bubl_snd_mix

Overview:
- Audio back-end of the sound board.
- Removes the DC offset from the unsigned PSG output of the YM2203-class chip (jt03).
- Mixes that PSG signal with two signed FM streams and one spare 8-bit channel through per-channel gains.
- Produces one saturated signed 16-bit sample stream, running at the 3 MHz sound clock enable.

Parameters:
- W0, 16: width of signed channel 0 (FM0).
- W1, 16: width of signed channel 1 (FM1).
- W2, 10: width of the PSG input (unsigned) and of the DC-removed PSG value (signed).
- W3, 8: width of signed channel 3.
- WOUT, 16: output width.
- AVG_SH, 10: DC-average time-constant shift (2^AVG_SH cen ticks).

Ports:
- clk, input, 1: system clock.
- snd_rstn, input, 1: reset, asynchronous, active-low.
- cen, input, 1: 3 MHz clock enable; all state advances only when cen=1.
- fm0_snd, input, W0: signed FM channel 0.
- fm1_snd, input, W1: signed FM channel 1.
- psg_snd, input, W2: unsigned PSG sum.
- ch3, input, W3: signed spare channel.
- gain0..gain3, input, 8 each: unsigned 4.4 gains; 8'h10 = unity.
- psg_dc, output, W2: signed DC-removed PSG value.
- snd, output, WOUT: signed mixed output.

Behaviour:
- Reset (snd_rstn=0, asynchronous): all of the following are 0 immediately:
  - DC accumulator acc (W2+AVG_SH bits, unsigned).
  - psg_dc.
  - Product registers.
  - snd.
- No state changes while cen=0.
- DC remover, on each cen tick:
  - avg = acc >> AVG_SH (W2 bits).
  - acc <= acc + psg_snd - avg. No overflow is possible by construction.
  - diff = {0,psg_snd} - {0,avg}, signed W2+1 bits.
  - psg_dc <= diff >>> 1 (arithmetic shift, W2 bits); range -512..511 for W2=10.
  - Latency: 1 cen tick.
- Mixer stage 1, on each cen tick:
  - Each channel is sign-extended, value-preserving with no MSB alignment, to WM = max(W0,W1,W2,W3)+2 bits.
  - Inputs are fm0_snd, fm1_snd, psg_dc and ch3.
  - Each extended channel is multiplied by its gain treated as unsigned (result WM+8 bits signed).
  - Products p0..p3 are registered.
- Mixer stage 2, on each cen tick:
  - sum = (p0+p1+p2+p3) >>> 4 (arithmetic).
  - snd <= sum saturated to the WOUT signed range: >32767 → 32767, <-32768 → -32768.
- Latency: snd reflects FM/ch3 inputs 2 cen ticks after they are sampled; the PSG path takes 3 ticks.
- Gain 0 mutes its channel fully; gain 8'hFF gives ×15.9375.
- Simultaneous full-scale inputs must saturate, never wrap.

Optional Feature:
- Macro BUBL_MIX_PEAK_EN.
- When defined:
  - Adds output port peak (1 bit).
  - peak is set on any cen tick where stage-2 saturation engages.
  - peak is sticky until reset.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package bubl_snd_pkg holds:
  - The UNITY_GAIN constant (8'h10).
  - Default width constants.
  - A saturate function (input width → WOUT).
- One sub-module, bubl_psg_dcrm, implements the DC remover (ports: clk, snd_rstn, cen, din, dout; params W2, AVG_SH).
- The mixer stays in the top-level module.

Test Plan:
- Assert snd_rstn=0 mid-stream with nonzero inputs → snd=0, psg_dc=0 immediately; after release with all inputs 0, snd stays 0.
- fm0_snd=1000, others 0, gain0=8'h10 → snd=1000 on 2nd cen tick; no change while cen held low.
- fm0_snd=1000, gain0=8'h08 → snd=500. gain0=8'h20 → snd=2000. gain0=0 → snd=0.
- Saturation:
  - fm0=fm1=30000, gains 8'h10 → snd=32767.
  - fm0=fm1=-30000 → snd=-32768.
  - peak=1 when BUBL_MIX_PEAK_EN is defined.
- psg_snd held at 512 from reset:
  - First tick: psg_dc=256.
  - After 20×1024 cen ticks: |psg_dc|≤1.
  - Then step psg_snd to 0 → psg_dc ≈ -256.
- Mix: fm0=100, fm1=-50, psg settled, ch3=8'sd-4, all gains 8'h10 → snd=46 (±1 for psg residue).
